// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit drain.
// Contents: tx_state_t FSM encoding, line levels, counter width helper.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state encoding).
package uart_pkg;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd6
  } tx_state_t;

  // $clog2 with a floor of 1 so a counter for a tiny range still has a bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: free-running 0..CLKS_PER_BIT-1 counter, held at 0 by clear.
// Ports: clk, rst_n (async active-low), clear (sync hold-at-zero),
//        bit_tick (high on the count == CLKS_PER_BIT-1 cycle, decoded from the count register).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign bit_tick = (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Serial transmitter that pops one word per frame from a synchronous FIFO and
// sends start bit, DATA_WIDTH data bits LSB first, optional even parity, stop bits.
// Ports: clk, rst_n (async active-low), tx_en (gates new frames only), fifo_empty,
//        fifo_rd_en (1-cycle pop strobe), fifo_rd_data (valid the cycle after the pop),
//        txd (serial line, idles high), busy (not IDLE), tx_done (final stop-bit cycle).
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit after the data.
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 7,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int BCW = cnt_width(DATA_WIDTH + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BCW-1:0]        bit_cnt;
  logic                  bit_tick;
  logic                  baud_clear;
`ifdef UART_TX_PARITY_EN
  logic                  parity_bit;
`endif

  // Hold the baud counter at zero until the frame starts so the start bit
  // gets a full CLKS_PER_BIT cycles measured from the first START cycle.
  assign baud_clear = (state == IDLE) || (state == FETCH) || (state == LOAD);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clear),
    .bit_tick(bit_tick)
  );

  // Decoded from registers only (state, stop-bit count, baud count).
  assign tx_done = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      txd        <= IDLE_LEVEL;
      busy       <= 1'b0;
      fifo_rd_en <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd <= IDLE_LEVEL;
          if (tx_en && !fifo_empty) begin
            state      <= FETCH;
            fifo_rd_en <= 1'b1;
            busy       <= 1'b1;
          end
        end
        FETCH: begin
          fifo_rd_en <= 1'b0;
          state      <= LOAD;
        end
        LOAD: begin
          // Read data is valid now, one cycle after the pop strobe.
          shreg   <= fifo_rd_data;
          bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^fifo_rd_data;
`endif
          txd     <= START_LEVEL;
          state   <= START;
        end
        START: begin
          if (bit_tick) begin
            txd   <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              txd     <= parity_bit;
              state   <= PARITY;
`else
              txd     <= IDLE_LEVEL;
              state   <= STOP;
`endif
            end else begin
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            txd   <= IDLE_LEVEL;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          // bit_cnt is reused to count stop bits.
          if (bit_tick) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          txd        <= IDLE_LEVEL;
          busy       <= 1'b0;
          fifo_rd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain at DATA_WIDTH=7, CLKS_PER_BIT=4, STOP_BITS=1.
// A behavioural FIFO feeds the DUT; every txd cycle of each frame is compared.
// Build with UART_TX_PARITY_EN defined to cover the parity frame format.
module tb_uart_tx_drain;

  localparam int DW  = 7;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = 1 + DW + PB + SB;
  localparam int FRAME = NBITS * CPB;
  localparam int LIMIT = 300;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tx_en;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          txd;
  logic          busy;
  logic          tx_done;

  logic [DW-1:0] mem [0:63];
  int wr_idx = 0;
  int rd_idx = 0;
  int rd_cnt = 0;
  int done_cnt = 0;
  int underflow = 0;
  int rd_long = 0;
  logic rd_prev = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign fifo_empty = (rd_idx == wr_idx);

  uart_tx_drain #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .STOP_BITS   (SB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_en       (tx_en),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .txd         (txd),
    .busy        (busy),
    .tx_done     (tx_done)
  );

  // FIFO model plus event counters.
  always @(posedge clk) begin
    rd_prev <= fifo_rd_en;
    if (fifo_rd_en && rd_prev) rd_long <= rd_long + 1;
    if (tx_done) done_cnt <= done_cnt + 1;
    if (fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (rd_idx == wr_idx) underflow <= underflow + 1;
      else begin
        fifo_rd_data <= mem[rd_idx % 64];
        rd_idx <= rd_idx + 1;
      end
    end
  end

  task automatic push(input logic [DW-1:0] w);
    mem[wr_idx % 64] = w;
    wr_idx = wr_idx + 1;
  endtask

  // Counts high negedges until txd falls; ok=0 if it never does.
  task automatic wait_start(output int gap, output bit ok);
    gap = 0;
    ok = 1'b0;
    for (int k = 0; k < LIMIT; k++) begin
      @(negedge clk);
      if (txd === 1'b0) begin
        ok = 1'b1;
        break;
      end
      gap++;
    end
  endtask

  task automatic check_start(input string name, input int req_gap);
    int gap;
    bit ok;
    wait_start(gap, ok);
    checks++;
    if (!ok || gap != req_gap) begin
      errors++;
      $display("FAIL %s start: found=%0d gap=%0d, required found=1 gap=%0d", name, ok, gap, req_gap);
    end
  endtask

  // Called on the negedge of the first start-bit cycle; ends on the last stop cycle.
  task automatic check_frame(input logic [DW-1:0] w, input string name, input int drop_at);
    logic [NBITS-1:0] exp_v;
    int bad_txd = 0, bad_busy = 0, extra_done = 0, done_at = -1;
    exp_v = '1;
    exp_v[0] = 1'b0;
    for (int b = 0; b < DW; b++) exp_v[1+b] = w[b];
    if (PB == 1) exp_v[1+DW] = ^w;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      if (i == drop_at) tx_en = 1'b0;
      if (txd !== exp_v[i/CPB]) bad_txd++;
      if (busy !== 1'b1) bad_busy++;
      if (tx_done === 1'b1) begin
        if (done_at < 0) done_at = i;
        else extra_done++;
      end
    end
    checks++;
    if (bad_txd != 0) begin
      errors++;
      $display("FAIL %s txd: %0d wrong cycles, required 0 (word %h)", name, bad_txd, w);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s busy: %0d low cycles in frame, required 0", name, bad_busy);
    end
    checks++;
    if (done_at != FRAME - 1 || extra_done != 0) begin
      errors++;
      $display("FAIL %s tx_done: first at %0d extra %0d, required at %0d extra 0", name, done_at, extra_done, FRAME - 1);
    end
  endtask

  task automatic test_reset();
    int b_txd = 0, b_busy = 0, b_rd = 0, b_done = 0, b_idle = 0;
    rst_n = 1'b0;
    tx_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (txd !== 1'b1) b_txd++;
      if (busy !== 1'b0) b_busy++;
      if (fifo_rd_en !== 1'b0) b_rd++;
      if (tx_done !== 1'b0) b_done++;
    end
    checks++; if (b_txd != 0)  begin errors++; $display("FAIL reset txd: %0d cycles not 1, required 0", b_txd); end
    checks++; if (b_busy != 0) begin errors++; $display("FAIL reset busy: %0d cycles not 0, required 0", b_busy); end
    checks++; if (b_rd != 0)   begin errors++; $display("FAIL reset rd_en: %0d cycles not 0, required 0", b_rd); end
    checks++; if (b_done != 0) begin errors++; $display("FAIL reset tx_done: %0d cycles not 0, required 0", b_done); end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) b_idle++;
    end
    checks++;
    if (b_idle != 0 || rd_cnt != 0) begin
      errors++;
      $display("FAIL idle_empty: %0d bad cycles, %0d reads, required 0 and 0", b_idle, rd_cnt);
    end
  endtask

  task automatic test_single();
    int c0 = rd_cnt, d0 = done_cnt;
    push(7'h55);
    check_start("single", 2);
    check_frame(7'h55, "single", -1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL single after: busy=%b txd=%b, required 0 1", busy, txd);
    end
    checks++;
    if (rd_cnt - c0 != 1 || rd_long != 0) begin
      errors++;
      $display("FAIL single rd_en: pulses=%0d long=%0d, required 1 0", rd_cnt - c0, rd_long);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL single done count: %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int c0 = rd_cnt, d0 = done_cnt;
    push(7'h01);
    push(7'h7F);
    push(7'h2A);
    check_start("b2b_0", 2);
    check_frame(7'h01, "b2b_0", -1);
    check_start("b2b_1", 3);
    check_frame(7'h7F, "b2b_1", -1);
    check_start("b2b_2", 3);
    check_frame(7'h2A, "b2b_2", -1);
    repeat (20) @(negedge clk);
    checks++;
    if (rd_cnt - c0 != 3 || underflow != 0 || rd_long != 0) begin
      errors++;
      $display("FAIL b2b reads: pulses=%0d underflow=%0d long=%0d, required 3 0 0", rd_cnt - c0, underflow, rd_long);
    end
    checks++;
    if (done_cnt - d0 != 3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b end: done=%0d busy=%b, required 3 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_tx_en_gate();
    int c0, bad = 0;
    push(7'h11);
    push(7'h22);
    check_start("gate_0", 2);
    check_frame(7'h11, "gate_0", 3 * CPB);
    c0 = rd_cnt;
    repeat (30) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || rd_cnt != c0) begin
      errors++;
      $display("FAIL gate hold: %0d bad cycles, %0d reads, required 0 and 0", bad, rd_cnt - c0);
    end
    tx_en = 1'b1;
    check_start("gate_1", 2);
    check_frame(7'h22, "gate_1", -1);
  endtask

  task automatic test_reset_mid();
    int c0;
    push(7'h3C);
    push(7'h5A);
    check_start("rstmid_0", 2);
    repeat (2 * CPB + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL rstmid async: txd=%b busy=%b rd_en=%b, required 1 0 0", txd, busy, fifo_rd_en);
    end
    repeat (2) @(negedge clk);
    c0 = rd_cnt;
    rst_n = 1'b1;
    check_start("rstmid_1", 2);
    check_frame(7'h5A, "rstmid_1", -1);
    checks++;
    if (rd_cnt - c0 != 1) begin
      errors++;
      $display("FAIL rstmid reads: %0d, required 1", rd_cnt - c0);
    end
  endtask

  // Word 03 has even parity 0, word 07 has 1; only visible with UART_TX_PARITY_EN.
  task automatic test_parity();
    push(7'h03);
    push(7'h07);
    check_start("par_0", 2);
    check_frame(7'h03, "par_0", -1);
    check_start("par_1", 3);
    check_frame(7'h07, "par_1", -1);
  endtask

  initial begin
    rst_n = 1'b0;
    tx_en = 1'b0;
    test_reset();
    test_single();
    repeat (5) @(negedge clk);
    test_back_to_back();
    test_tx_en_gate();
    repeat (5) @(negedge clk);
    test_reset_mid();
    repeat (5) @(negedge clk);
    test_parity();
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
